instruction_fetch_unit: RTL

Fetch-side initiator for the single-cycle instruction memory. It holds the program counter and drives a word address to the memory every cycle. It captures the combinationally returned instruction into a 2-entry buffer and presents {pc, instr} pairs to decode over a valid/ready handshake. Branch and jump redirects from execute flush the buffer and reload the PC.

---
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, single-cycle imem initiator, 2-entry {pc, instr} buffer to decode.
// Optional perf counters compiled in with IFU_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_stall_count
`endif
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] slot_pc_q    [2];
  logic [31:0] slot_pc_d    [2];
  logic [31:0] slot_instr_q [2];
  logic [31:0] slot_instr_d [2];

  logic       pop;
  logic       push;
  logic [1:0] count_after_pop;

  assign pop             = (count_q != 2'd0) && out_ready;
  assign push            = !redirect_valid && ((count_q < 2'd2) || pop);
  assign count_after_pop = count_q - {1'b0, pop};

  // Slot 0 is always the head; it keeps its old contents when emptied so the outputs never toggle.
  always_comb begin
    pc_d         = pc_q;
    count_d      = count_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 2'd0;
    end else begin
      if (pop && count_q == 2'd2) begin
        slot_pc_d[0]    = slot_pc_q[1];
        slot_instr_d[0] = slot_instr_q[1];
      end
      if (push) begin
        slot_pc_d[count_after_pop[0]]    = pc_q;
        slot_instr_d[count_after_pop[0]] = imem_instr;
        pc_d                             = pc_q + 32'd4;
      end
      count_d = count_after_pop + {1'b0, push};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC_ALIGNED;
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        slot_pc_q[i]    <= 32'd0;
        slot_instr_q[i] <= 32'd0;
      end
    end else begin
      pc_q         <= pc_d;
      count_q      <= count_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = slot_pc_q[0];
  assign out_instr = slot_instr_q[0];

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  // Counters survive redirects; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (push) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (count_q == 2'd2 && !pop) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_count = perf_fetch_q;
  assign perf_stall_count = perf_stall_q;
`endif

endmodule
